uart_fifo: RTL and testbench
============================

// Module: uart_fifo
// PURPOSE
//  Memory-mapped UART peripheral with runtime baud divisor, optional parity, 1/2 stop bits,
//  and RX/TX FIFOs. Sits on the SoC peripheral bus (mem_* signals) beside the other perips;
//  raises a level interrupt on RX data available / TX FIFO empty.
// PARAMETERS
//  BASE_ADDR   32'hffff0020  register block base; offsets below are added to it
//  DATA_BITS   8             data bits per frame (5..8); RXDT/TXDT use bits [DATA_BITS-1:0]
//  FIFO_DEPTH  8             entries per FIFO, power of two, >=2
//  BAUD_RST    16'd433       reset value of BAUD (bit period = BAUD+1 clk cycles)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous active-low reset
//  mem_we     in   1   write strobe, one cycle per access
//  mem_re     in   1   read strobe, one cycle per access
//  mem_addr   in   32  byte address; only exact BASE_ADDR+offset matches decode
//  mem_wdata  in   32  write data
//  mem_rdata  out  32  read data, combinational; 0 when !mem_re or no match
//  uart_rx    in   1   serial input (asynchronous, idle high)
//  uart_tx    out  1   serial output (idle high)
//  irq        out  1   level interrupt
// BEHAVIOUR
//  Registers: 0x00 RXDT(R, pops RX FIFO; 0 if empty) 0x04 TXDT(W, pushes TX FIFO)
//   0x08 CTRL(RW) [0]rx_en [1]tx_en [2]par_en [3]par_odd [4]two_stop [5]ie_rx [6]ie_tx
//   0x0C STAT(R; W1C on [7:4]) [0]rx_nempty [1]tx_busy [2]tx_full [3]rx_full
//        [4]rx_overrun [5]parity_err [6]frame_err [7]tx_drop   0x10 BAUD(RW)[15:0]
//  Reset: CTRL=0, STAT sticky=0, BAUD=BAUD_RST, FIFOs empty, uart_tx=1, irq=0, FSMs IDLE.
//  irq = (ie_rx & rx_nempty) | (ie_tx & tx FIFO empty & !tx_busy).
//  FIFO: push when !full, or when full with same-cycle pop; simultaneous push+pop keeps count.
//   Pointers log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
//  TXDT write when TX FIFO full (and no same-cycle pop) -> dropped, tx_drop set.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP1->[STOP2]->IDLE; each state lasts BAUD+1 clk.
//   Leaves IDLE when tx_en & FIFO non-empty: pops entry, latches BAUD/CTRL for the frame.
//   LSB first; parity = XOR(data) ^ par_odd. tx_busy=1 outside IDLE.
//   tx_en cleared mid-frame: frame completes, no further pop. Back-to-back frames: no idle gap.
//  RX: uart_rx through 2-flop synchroniser; FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   IDLE: falling edge with rx_en -> START, wait (BAUD>>1) cycles, resample; high -> IDLE
//   (false start, no flags). Data/parity/stop sampled every BAUD+1 cycles thereafter (mid-bit).
//   Stop=0 -> byte discarded, frame_err set. Parity mismatch -> byte pushed, parity_err set.
//   Push into full RX FIFO (no same-cycle pop) -> byte dropped, rx_overrun set.
//   Stop sampled -> IDLE immediately (next start edge accepted in half-stop-bit window).
//   rx_en cleared mid-frame -> abort to IDLE, nothing pushed. Only one stop bit checked.
//  BAUD/CTRL writes mid-frame take effect at next frame start (both FSMs).
//  W1C: write 1 to STAT[7:4] clears; same-cycle set event wins over clear.
//  Async reset mid-frame: everything to reset values; uart_tx high within reset assertion.
// TESTING
//  BAUD=9, CTRL=0x02, write TXDT=0xA5 -> uart_tx low 10 clk, bits 1,0,1,0,0,1,0,1, high 10 clk.
//  Loopback tx->rx, CTRL=0x07 (even parity), send 0x00..0x07 -> RXDT reads same, no error flags.
//  Rx disabled readers, drive 9 frames FIFO_DEPTH=8 -> rx_full=1, rx_overrun=1, first 8 bytes intact.
//  Drive frame with stop bit 0 -> frame_err=1, rx_nempty=0; write STAT=0x40 -> frame_err=0.
//  Write 9 TXDT with tx_en=0 -> tx_full=1, tx_drop=1; set tx_en -> 8 back-to-back frames.
//  2-clk low glitch on uart_rx (BAUD=9) -> no push, no flags; assert rst mid-TX -> uart_tx=1.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo_buf / uart_fifo
//
// Purpose: memory-mapped UART peripheral. It has a runtime baud divisor,
// optional parity, and one or two TX stop bits. RX and TX each have a FIFO.
// It raises a level interrupt when RX data is available or when the
// transmitter has gone fully idle.
//
// uart_fifo ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   mem_we     bus write strobe (one cycle per access)
//   mem_re     bus read strobe (one cycle per access)
//   mem_addr   bus byte address; only exact BASE_ADDR+offset decodes
//   mem_wdata  bus write data
//   mem_rdata  bus read data, combinational, 0 unless a decoded read
//   uart_rx    serial input, asynchronous, idle high
//   uart_tx    serial output, idle high
//   irq        level interrupt
//
// Register map (offsets from BASE_ADDR):
//   0x00 RXDT  R    pops the RX FIFO (reads 0 when empty)
//   0x04 TXDT  W    pushes the TX FIFO
//   0x08 CTRL  RW   [0]rx_en [1]tx_en [2]par_en [3]par_odd [4]two_stop
//                   [5]ie_rx [6]ie_tx
//   0x0C STAT  R    [0]rx_nempty [1]tx_busy [2]tx_full [3]rx_full
//              W1C  [4]rx_overrun [5]parity_err [6]frame_err [7]tx_drop
//   0x10 BAUD  RW   [15:0], bit period = BAUD+1 clocks

// Small synchronous FIFO shared by both directions. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'hffff0020,
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RST   = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Address decode and register file
  logic sel_rxdt, sel_txdt, sel_ctrl, sel_stat, sel_baud;
  assign sel_rxdt = (mem_addr == BASE_ADDR);
  assign sel_txdt = (mem_addr == BASE_ADDR + 32'h4);
  assign sel_ctrl = (mem_addr == BASE_ADDR + 32'h8);
  assign sel_stat = (mem_addr == BASE_ADDR + 32'hC);
  assign sel_baud = (mem_addr == BASE_ADDR + 32'h10);

  logic [6:0]  ctrl;
  logic [15:0] baud;
  logic [3:0]  sticky;   // {tx_drop, frame_err, parity_err, rx_overrun}
  logic [7:0]  stat;

  logic rx_en, tx_en;
  assign rx_en = ctrl[0];
  assign tx_en = ctrl[1];

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:16];

  // FIFOs
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;
  logic [DATA_BITS-1:0] rx_shift;

  assign tx_push = mem_we & sel_txdt;
  assign rx_pop  = mem_re & sel_rxdt & ~rx_empty;

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(mem_wdata[DATA_BITS-1:0]), .rdata(tx_head),
    .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(rx_shift), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty)
  );

  // Transmitter
  tx_state_t            tx_state;
  logic [15:0]          tx_cnt;
  logic [15:0]          tx_baud;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_en, tx_parity, tx_two_stop, tx_line;
  logic                 tx_tick, tx_frame_end, tx_start, tx_busy;

  assign tx_tick      = (tx_cnt == '0);
  assign tx_frame_end = tx_tick & (((tx_state == TX_STOP1) & ~tx_two_stop) |
                                   (tx_state == TX_STOP2));
  // A new frame may start from idle or straight out of the last stop bit,
  // which is what gives back-to-back frames with no idle gap.
  assign tx_start = tx_en & ~tx_empty & ((tx_state == TX_IDLE) | tx_frame_end);
  assign tx_pop   = tx_start;
  assign tx_busy  = (tx_state != TX_IDLE);
  assign uart_tx  = tx_line;

  // Baud and framing options are snapshotted at frame start so that bus
  // writes made mid-frame only affect the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_baud     <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_par_en   <= 1'b0;
      tx_parity   <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_line     <= 1'b1;
    end else if (tx_start) begin
      tx_state    <= TX_START;
      tx_line     <= 1'b0;
      tx_cnt      <= baud;
      tx_baud     <= baud;
      tx_bit      <= '0;
      tx_shift    <= tx_head;
      tx_par_en   <= ctrl[2];
      tx_parity   <= (^tx_head) ^ ctrl[3];
      tx_two_stop <= ctrl[4];
    end else if (tx_state == TX_IDLE) begin
      tx_line <= 1'b1;
    end else if (!tx_tick) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= tx_baud;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_line  <= tx_shift[0];
        end
        TX_DATA: begin
          if (tx_bit == LAST_BIT) begin
            tx_state <= tx_par_en ? TX_PARITY : TX_STOP1;
            tx_line  <= tx_par_en ? tx_parity : 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
            tx_line  <= tx_shift[1];
          end
        end
        TX_PARITY: begin
          tx_state <= TX_STOP1;
          tx_line  <= 1'b1;
        end
        TX_STOP1: begin
          tx_state <= tx_two_stop ? TX_STOP2 : TX_IDLE;
          tx_line  <= 1'b1;
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  // Receiver
  logic [1:0]  rx_sync;
  logic        rx_prev, rx_s, rx_fall;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [15:0] rx_baud;
  logic [2:0]  rx_bit;
  logic        rx_par_en, rx_par_odd, rx_par_bit;
  logic        rx_tick, rx_stop_sample;
  logic        frame_err_evt, parity_err_evt, rx_overrun_evt, tx_drop_evt;

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;
  assign rx_tick = (rx_cnt == '0);

  assign rx_stop_sample = rx_en & (rx_state == RX_STOP) & rx_tick;
  assign rx_push        = rx_stop_sample & rx_s;
  assign frame_err_evt  = rx_stop_sample & ~rx_s;
  assign parity_err_evt = rx_push & rx_par_en & ((^rx_shift) ^ rx_par_odd ^ rx_par_bit);
  assign rx_overrun_evt = rx_push & rx_full & ~rx_pop;
  assign tx_drop_evt    = tx_push & tx_full & ~tx_pop;

  // Synchroniser plus a delayed copy for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_sync[1];
    end
  end

  // START waits half a bit to land mid-bit, then every later sample is one
  // full bit period on. Clearing rx_en drops any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_baud    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
    end else if (!rx_en) begin
      rx_state <= RX_IDLE;
    end else if (rx_state == RX_IDLE) begin
      if (rx_fall) begin
        rx_state   <= RX_START;
        rx_cnt     <= baud >> 1;
        rx_baud    <= baud;
        rx_bit     <= '0;
        rx_par_en  <= ctrl[2];
        rx_par_odd <= ctrl[3];
      end
    end else if (!rx_tick) begin
      rx_cnt <= rx_cnt - 16'd1;
    end else begin
      rx_cnt <= rx_baud;
      case (rx_state)
        RX_START: rx_state <= rx_s ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
          else                    rx_bit   <= rx_bit + 3'd1;
        end
        RX_PARITY: begin
          rx_par_bit <= rx_s;
          rx_state   <= RX_STOP;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Control registers and sticky status. A set event in the same cycle as a
  // W1C clear wins, so no error is ever silently lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= '0;
      baud   <= BAUD_RST;
      sticky <= '0;
    end else begin
      if (mem_we & sel_ctrl) ctrl <= mem_wdata[6:0];
      if (mem_we & sel_baud) baud <= mem_wdata[15:0];
      sticky <= (sticky & ~((mem_we & sel_stat) ? mem_wdata[7:4] : 4'b0000)) |
                {tx_drop_evt, frame_err_evt, parity_err_evt, rx_overrun_evt};
    end
  end

  assign stat = {sticky, rx_full, tx_full, tx_busy, ~rx_empty};
  assign irq  = (ctrl[5] & ~rx_empty) | (ctrl[6] & tx_empty & ~tx_busy);

  always_comb begin
    mem_rdata = '0;
    if (mem_re) begin
      if (sel_rxdt && !rx_empty) mem_rdata[DATA_BITS-1:0] = rx_head;
      if (sel_ctrl)              mem_rdata[6:0]           = ctrl;
      if (sel_stat)              mem_rdata[7:0]           = stat;
      if (sel_baud)              mem_rdata[15:0]          = baud;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo
//
// Purpose: directed and randomized bench for uart_fifo. The bench models
// serial frames from the framing rules with plain arithmetic. Expected FIFO
// contents are kept in queues.
// Ports: none (top-level bench).
module tb_uart_fifo;
  localparam logic [31:0] BASE = 32'hffff0020;
  localparam int BIT = 10;   // BAUD=9 gives a 10-clock bit period
  localparam logic [7:0] RXDT = 8'h00, TXDT = 8'h04, CTRL = 8'h08,
                         STAT = 8'h0C, BAUD = 8'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        irq;
  logic        drv_rx = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;

  assign rx_line = loop_en ? uart_tx : drv_rx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .uart_rx(rx_line), .uart_tx(uart_tx), .irq(irq)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = BASE + {24'b0, off}; mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic busRead(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    mem_re = 1'b1; mem_addr = BASE + {24'b0, off};
    #1 d = mem_rdata;
    @(negedge clk);
    mem_re = 1'b0; mem_addr = '0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame model: start 0, data LSB first, optional parity, then stop ones.
  function automatic logic [11:0] frameOf(input logic [7:0] d, input bit pe,
                                          input bit po);
    logic [11:0] f;
    bit par;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    par = ($countones(d) % 2) == 1;
    if (pe) f[9] = par ^ po;
    return f;
  endfunction

  // Drive one frame onto uart_rx, optionally corrupting parity or stop.
  task automatic applyStimulus(input logic [7:0] d, input bit pe, input bit po,
                               input bit bad_par, input bit stop_val);
    logic [11:0] f;
    int n;
    f = frameOf(d, pe, po);
    if (bad_par) f[9] = ~f[9];
    if (!stop_val) f[9 + int'(pe)] = 1'b0;
    n = 10 + int'(pe);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      drv_rx = f[i];
      repeat (BIT) @(negedge clk);
    end
    drv_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Sample one transmitted frame mid-bit; a timeout leaves the start bit 1.
  task automatic captureFrame(input int n, output logic [11:0] bits,
                              output int t);
    int w;
    bits = '1;
    w = 0;
    while (uart_tx !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    t = cyc;
    repeat (BIT/2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bits[i] = uart_tx;
      if (i < n - 1) repeat (BIT) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0]  rd;
    logic [11:0]  got;
    logic [11:0]  f;
    logic [127:0] wave;
    logic [127:0] exp_wave;
    logic [7:0]   q[$];
    logic [7:0]   d;
    bit           pe, po, ts, gap_ok;
    int           t, tprev, w;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_uart_tx", uart_tx, 1'b1);
    checkOutput("reset_irq", irq, 1'b0);
    rst = 1'b1;
    busRead(CTRL, rd); checkOutput("reset_ctrl", rd, 32'h0);
    busRead(BAUD, rd); checkOutput("reset_baud", rd, 32'd433);
    busRead(STAT, rd); checkOutput("reset_stat", rd, 32'h0);
    busRead(8'h14, rd); checkOutput("unmapped_read", rd, 32'h0);
    @(negedge clk);
    mem_addr = BASE + 32'h10;
    #1 checkOutput("rdata_no_re", mem_rdata, 32'h0);
    mem_addr = '0;

    // Exact TX waveform for 0xA5, 8N1
    busWrite(BAUD, 32'd9);
    busRead(BAUD, rd); checkOutput("baud_rw", rd, 32'd9);
    busWrite(CTRL, 32'h02);
    busWrite(TXDT, 32'hA5);
    w = 0;
    while (uart_tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    wave = '0;
    for (int i = 0; i < 100; i++) begin
      wave[i] = uart_tx;
      @(negedge clk);
    end
    f = frameOf(8'hA5, 1'b0, 1'b0);
    exp_wave = '0;
    for (int i = 0; i < 100; i++) exp_wave[i] = f[i / BIT];
    checkOutput("tx_wave_a5", wave, exp_wave);

    // Random TX framing options
    for (int k = 0; k < 4; k++) begin
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      busWrite(CTRL, 32'h2 | (32'(pe) << 2) | (32'(po) << 3) | (32'(ts) << 4));
      busWrite(TXDT, {24'b0, d});
      captureFrame(10 + int'(pe) + int'(ts), got, t);
      checkOutput("tx_frame_rand", got, frameOf(d, pe, po));
    end
    waitCycles(20);

    // Loopback, even parity, 0x00..0x07
    loop_en = 1'b1;
    busWrite(CTRL, 32'h07);
    for (int i = 0; i < 8; i++) busWrite(TXDT, 32'(i));
    waitCycles(8 * 11 * BIT + 100);
    for (int i = 0; i < 8; i++) begin
      busRead(RXDT, rd);
      checkOutput("loop_seq", rd, 32'(i));
    end
    busRead(STAT, rd); checkOutput("loop_seq_stat", rd, 32'h0);

    // Loopback with random odd/even parity and stop count
    po = 1'($urandom_range(0, 1));
    ts = 1'($urandom_range(0, 1));
    busWrite(CTRL, 32'h07 | (32'(po) << 3) | (32'(ts) << 4));
    q.delete();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      busWrite(TXDT, {24'b0, d});
    end
    waitCycles(6 * 12 * BIT + 100);
    for (int i = 0; i < 6; i++) begin
      busRead(RXDT, rd);
      checkOutput("loop_rand", rd, {24'b0, q[i]});
    end
    busRead(STAT, rd); checkOutput("loop_rand_stat", rd, 32'h0);
    loop_en = 1'b0;

    // RX overrun: nine frames into an eight-deep FIFO
    busWrite(CTRL, 32'h01);
    q.delete();
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    busRead(STAT, rd); checkOutput("overrun_stat", rd, 32'h19);
    for (int i = 0; i < 8; i++) begin
      busRead(RXDT, rd);
      checkOutput("overrun_data", rd, {24'b0, q[i]});
    end
    busRead(RXDT, rd); checkOutput("rx_empty_read", rd, 32'h0);
    busRead(STAT, rd); checkOutput("overrun_sticky", rd, 32'h10);
    busWrite(STAT, 32'h10);
    busRead(STAT, rd); checkOutput("overrun_clear", rd, 32'h0);

    // Frame error: stop bit driven low
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    busRead(STAT, rd); checkOutput("frame_err_stat", rd, 32'h40);
    busWrite(STAT, 32'h40);
    busRead(STAT, rd); checkOutput("frame_err_clear", rd, 32'h0);

    // Parity error: byte still delivered, rx interrupt follows FIFO state
    busWrite(CTRL, 32'h25);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("irq_rx", irq, 1'b1);
    busRead(STAT, rd); checkOutput("parity_err_stat", rd, 32'h21);
    busRead(RXDT, rd); checkOutput("parity_err_data", rd, 32'h3C);
    checkOutput("irq_rx_clear", irq, 1'b0);
    busWrite(STAT, 32'h20);
    busRead(STAT, rd); checkOutput("parity_err_clear", rd, 32'h0);

    // TX drop, then eight back-to-back frames
    busWrite(CTRL, 32'h00);
    q.delete();
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      busWrite(TXDT, {24'b0, d});
    end
    busRead(STAT, rd); checkOutput("tx_drop_stat", rd, 32'h84);
    busWrite(STAT, 32'h80);
    busRead(STAT, rd); checkOutput("tx_drop_clear", rd, 32'h04);
    busWrite(CTRL, 32'h02);
    gap_ok = 1'b1;
    tprev = 0;
    for (int i = 0; i < 8; i++) begin
      captureFrame(10, got, t);
      checkOutput("tx_b2b_frame", got, frameOf(q[i], 1'b0, 1'b0));
      if (i > 0 && (t - tprev) != 10 * BIT) gap_ok = 1'b0;
      tprev = t;
    end
    checkOutput("tx_b2b_no_gap", gap_ok, 1'b1);
    waitCycles(2 * BIT);
    busRead(STAT, rd); checkOutput("tx_done_stat", rd, 32'h0);
    busWrite(CTRL, 32'h42);
    checkOutput("irq_tx", irq, 1'b1);

    // Short glitch on uart_rx is rejected as a false start
    busWrite(CTRL, 32'h01);
    @(negedge clk);
    drv_rx = 1'b0;
    repeat (2) @(negedge clk);
    drv_rx = 1'b1;
    waitCycles(4 * BIT);
    busRead(STAT, rd); checkOutput("glitch_stat", rd, 32'h0);

    // Async reset in the middle of a frame
    busWrite(CTRL, 32'h02);
    busWrite(TXDT, 32'h00);
    waitCycles(3 * BIT);
    checkOutput("tx_mid_frame_low", uart_tx, 1'b0);
    #2 rst = 1'b0;
    #1 checkOutput("rst_mid_tx_high", uart_tx, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    busRead(CTRL, rd); checkOutput("rst2_ctrl", rd, 32'h0);
    busRead(BAUD, rd); checkOutput("rst2_baud", rd, 32'd433);
    busRead(STAT, rd); checkOutput("rst2_stat", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
